seven_sd_scan_decoder: RTL and testbench

- Reads a multiplexed seven-segment display bus and rebuilds the 32-bit display value that drives it.
- Inputs are the segment byte and the 4 digit enables.
- Used for on-board loopback self-test of the display signal generator and for logic-analyser-free checking.
- Only a digit that is stable and has a single active enable is accepted.
- The value output updates only once all four digits have been captured.

---
 rtl/seven_sd_scan_decoder.sv | 194 +++++++++++++++++++
 tb/tb_seven_sd_scan_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_sd_scan_decoder.sv
// Rebuilds the 32-bit value behind a multiplexed 7-seg bus; a digit is captured SETTLE_CYCLES+2 cycles after it settles, frame commits 1 cycle after the 4th digit.
// Latency as above; passive observer with no backpressure; unstable, blanked or multi-enable bus states are simply not captured.
module seven_sd_scan_decoder #(
    parameter int SETTLE_CYCLES      = 16,
    parameter bit ENABLE_ACTIVE_LOW  = 1'b1,
    parameter bit SEGMENT_ACTIVE_LOW = 1'b1,
    parameter int TIMEOUT_CYCLES     = 1048576
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  displayIn,
    input  logic [3:0]  enableIn,
    output logic [31:0] value,
    output logic        frameValid,
    output logic        valueChanged,
    output logic [3:0]  digitMask,
    output logic        stale,
    output logic        scanError
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]    EN_INV      = {4{ENABLE_ACTIVE_LOW}};
    localparam logic [7:0]    SEG_INV     = {8{SEGMENT_ACTIVE_LOW}};
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [SW-1:0] settleCnt;
    logic [SW-1:0] settleCntNext;
    logic [TW-1:0] idleCnt;

    logic [3:0]  enMeta;
    logic [3:0]  enSync;
    logic [7:0]  segMeta;
    logic [7:0]  segSync;
    logic [3:0]  en;
    logic [7:0]  seg;
    logic [3:0]  enPrev;
    logic [7:0]  segPrev;
    logic        enChanged;
    logic        pairChanged;
    logic        enOneHot;
    logic        enMultiHot;
    logic [1:0]  digitIdx;
    logic        capture;
    logic        commit;
    logic [3:0]  maskNext;
    logic [31:0] shadow;

    // Synchronizers reset to the inactive pin level so no spurious enable pattern follows reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            enMeta  <= EN_INV;
            enSync  <= EN_INV;
            segMeta <= SEG_INV;
            segSync <= SEG_INV;
            enPrev  <= '0;
            segPrev <= '0;
        end else begin
            enMeta  <= enableIn;
            enSync  <= enMeta;
            segMeta <= displayIn;
            segSync <= segMeta;
            enPrev  <= en;
            segPrev <= seg;
        end
    end

    assign en          = enSync ^ EN_INV;
    assign seg         = segSync ^ SEG_INV;
    assign enChanged   = (en != enPrev);
    assign pairChanged = enChanged || (seg != segPrev);
    assign enOneHot    = $onehot(en);
    assign enMultiHot  = ($countones(en) > 1);

    always_comb begin
        digitIdx = '0;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                digitIdx = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            settleCnt <= '0;
        end else begin
            state     <= stateNext;
            settleCnt <= settleCntNext;
        end
    end

    always_comb begin
        stateNext     = state;
        settleCntNext = settleCnt;
        capture       = 1'b0;
        if (enMultiHot) begin
            stateNext     = IDLE;
            settleCntNext = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enOneHot) begin
                        stateNext     = SETTLE;
                        settleCntNext = '0;
                    end
                end
                SETTLE: begin
                    if (en == 4'b0000) begin
                        stateNext     = IDLE;
                        settleCntNext = '0;
                    end else if (pairChanged) begin
                        settleCntNext = '0;
                    end else if (settleCnt == SETTLE_LAST) begin
                        capture       = 1'b1;
                        stateNext     = HOLD;
                        settleCntNext = '0;
                    end else begin
                        settleCntNext = settleCnt + SW'(1);
                    end
                end
                HOLD: begin
                    // Segment-only changes under the same enable are ignored until the enable moves.
                    if (enChanged) begin
                        stateNext     = (en == 4'b0000) ? IDLE : SETTLE;
                        settleCntNext = '0;
                    end
                end
                default: begin
                    stateNext     = IDLE;
                    settleCntNext = '0;
                end
            endcase
        end
    end

    assign commit = (digitMask == 4'b1111);

    // A capture on the commit cycle lands in the freshly cleared mask of the next frame.
    always_comb begin
        maskNext = digitMask;
        if (commit) begin
            maskNext = '0;
        end
        if (capture) begin
            maskNext[digitIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shadow       <= '0;
            digitMask    <= '0;
            value        <= '0;
            frameValid   <= 1'b0;
            valueChanged <= 1'b0;
            scanError    <= 1'b0;
        end else begin
            digitMask    <= maskNext;
            frameValid   <= commit;
            valueChanged <= commit && (shadow != value);
            scanError    <= enMultiHot && enChanged;
            if (commit) begin
                value <= shadow;
            end
            if (capture) begin
                shadow[{digitIdx, 3'b000} +: 8] <= seg;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            idleCnt <= '0;
        end else if (capture) begin
            idleCnt <= '0;
        end else if (idleCnt != TIMEOUT_MAX) begin
            idleCnt <= idleCnt + TW'(1);
        end
    end

    assign stale = (idleCnt == TIMEOUT_MAX);

endmodule

// File: tb/tb_seven_sd_scan_decoder.sv
// Directed bench for seven_sd_scan_decoder with a window-based reference model checked every cycle.
module tb_seven_sd_scan_decoder;

    localparam int S = 4;
    localparam int T = 64;

    logic        clk;
    logic        resetN;
    logic [7:0]  displayIn;
    logic [3:0]  enableIn;
    logic [31:0] value;
    logic        frameValid;
    logic        valueChanged;
    logic [3:0]  digitMask;
    logic        stale;
    logic        scanError;

    seven_sd_scan_decoder #(
        .SETTLE_CYCLES(S),
        .ENABLE_ACTIVE_LOW(1'b1),
        .SEGMENT_ACTIVE_LOW(1'b1),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .displayIn(displayIn),
        .enableIn(enableIn),
        .value(value),
        .frameValid(frameValid),
        .valueChanged(valueChanged),
        .digitMask(digitMask),
        .stale(stale),
        .scanError(scanError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCmp = 0;
    int nBad = 0;
    int fvCount = 0;
    int vcCount = 0;
    int errCount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a digit is taken once its synced (enable, segment) pair has been
    // one-hot and constant for S+1 consecutive cycles, and the enable has moved since the last take.
    logic [11:0] p1, p2;
    logic [11:0] win [0:S];
    logic        armed;
    logic [3:0]  mMask;
    logic [31:0] mShadow;
    logic [31:0] mValue;
    logic        eFv, eVc, eErr;
    int          cyc;
    int          lastCap;

    always @(posedge clk or negedge resetN) begin
        logic [11:0] q;
        logic [11:0] prevQ;
        logic        allEq;
        logic        cap;
        int          d;
        if (!resetN) begin
            p1 = '0;
            p2 = '0;
            for (int i = 0; i <= S; i++) win[i] = '0;
            armed = 1'b1;
            mMask = '0;
            mShadow = '0;
            mValue = '0;
            eFv = 1'b0;
            eVc = 1'b0;
            eErr = 1'b0;
            cyc = 0;
            lastCap = 0;
        end else begin
            q = p2;
            prevQ = win[S];
            for (int i = 0; i < S; i++) win[i] = win[i+1];
            win[S] = q;
            allEq = 1'b1;
            for (int i = 0; i <= S; i++) if (win[i] != q) allEq = 1'b0;
            eErr = ($countones(q[11:8]) >= 2) && (q[11:8] != prevQ[11:8]);
            if (q[11:8] != prevQ[11:8]) armed = 1'b1;
            cap = armed && ($countones(q[11:8]) == 1) && allEq;
            eFv = (mMask == 4'hF);
            eVc = eFv && (mShadow != mValue);
            if (eFv) begin
                mValue = mShadow;
                mMask = '0;
            end
            cyc++;
            if (cap) begin
                d = 0;
                for (int i = 0; i < 4; i++) if (q[8+i]) d = i;
                mShadow[8*d +: 8] = q[7:0];
                mMask[d] = 1'b1;
                armed = 1'b0;
                lastCap = cyc;
            end
            p2 = p1;
            p1 = {~enableIn, ~displayIn};
        end
    end

    always @(negedge clk) begin
        if (resetN) begin
            check("value", value, mValue);
            check("frameValid", 32'(frameValid), 32'(eFv));
            check("valueChanged", 32'(valueChanged), 32'(eVc));
            check("digitMask", 32'(digitMask), 32'(mMask));
            check("stale", 32'(stale), 32'((cyc - lastCap) >= T));
            check("scanError", 32'(scanError), 32'(eErr));
            if (frameValid) fvCount++;
            if (valueChanged) vcCount++;
            if (scanError) errCount++;
        end
    end

    task automatic hold(input logic [3:0] enRaw, input logic [7:0] segByte, input int n);
        enableIn = enRaw;
        displayIn = ~segByte;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic digit(input int d, input logic [7:0] segByte, input int n);
        logic [3:0] sel;
        sel = 4'b0001 << d;
        hold(~sel, segByte, n);
    endtask

    task automatic blank(input int n);
        hold(4'hF, 8'h00, n);
    endtask

    logic [7:0] frameA [0:3];
    logic [7:0] frameB [0:3];

    initial begin
        frameA[0] = 8'h12; frameA[1] = 8'h34; frameA[2] = 8'h56; frameA[3] = 8'h78;
        frameB[0] = 8'hDE; frameB[1] = 8'hAD; frameB[2] = 8'hBE; frameB[3] = 8'hEF;
        resetN = 1'b0;
        enableIn = 4'hF;
        displayIn = 8'hFF;
        #3;
        check("rst_value", value, 32'h0);
        check("rst_frameValid", 32'(frameValid), 32'h0);
        check("rst_digitMask", 32'(digitMask), 32'h0);
        check("rst_stale", 32'(stale), 32'h0);
        check("rst_scanError", 32'(scanError), 32'h0);
        #9 resetN = 1'b1;
        @(posedge clk);
        #1;

        // Full scan, then an identical repeat.
        for (int d = 0; d < 4; d++) digit(d, frameA[d], 8);
        blank(6);
        check("scan1_fv_count", 32'(fvCount), 32'd1);
        check("scan1_vc_count", 32'(vcCount), 32'd1);
        check("scan1_value", value, 32'h78563412);
        check("scan1_model_value", mValue, 32'h78563412);
        check("scan1_mask", 32'(digitMask), 32'h0);
        for (int d = 0; d < 4; d++) digit(d, frameA[d], 8);
        blank(6);
        check("scan2_fv_count", 32'(fvCount), 32'd2);
        check("scan2_vc_count", 32'(vcCount), 32'd1);
        check("scan2_value", value, 32'h78563412);

        // Digit 2 held too briefly, completed later with a new byte.
        digit(0, 8'h12, 8);
        digit(1, 8'h34, 8);
        digit(2, 8'h56, 3);
        digit(3, 8'h78, 8);
        blank(6);
        check("short_mask", 32'(digitMask), 32'b1011);
        check("short_fv_count", 32'(fvCount), 32'd2);
        digit(2, 8'h9A, 8);
        blank(4);
        check("late2_fv_count", 32'(fvCount), 32'd3);
        check("late2_vc_count", 32'(vcCount), 32'd2);
        check("late2_value", value, 32'h789A3412);

        // Two enables active mid-frame.
        digit(0, 8'h11, 8);
        hold(4'b0011, 8'h00, 5);
        check("err_count", 32'(errCount), 32'd1);
        check("err_mask_kept", 32'(digitMask), 32'b0001);
        digit(1, 8'h22, 8);
        digit(2, 8'h33, 8);
        digit(3, 8'h44, 8);
        blank(4);
        check("err_frame_value", value, 32'h44332211);
        check("err_frame_fv_count", 32'(fvCount), 32'd4);
        check("err_count_final", 32'(errCount), 32'd1);

        // Segments toggling under a steady enable, then held.
        for (int i = 0; i < 6; i++) digit(1, (i % 2) ? 8'hAA : 8'h55, 2);
        check("toggle_mask", 32'(digitMask), 32'h0);
        digit(1, 8'hAA, 8);
        check("stable_mask", 32'(digitMask), 32'b0010);

        // Scanning stops.
        blank(60);
        check("stale_early", 32'(stale), 32'h0);
        blank(10);
        check("stale_late", 32'(stale), 32'h1);

        // Asynchronous reset in the middle of a partial frame.
        digit(0, 8'h5A, 3);
        check("pre_rst_mask", 32'(digitMask), 32'b0010);
        check("pre_rst_stale", 32'(stale), 32'h1);
        #1 resetN = 1'b0;
        #1;
        check("arst_value", value, 32'h0);
        check("arst_mask", 32'(digitMask), 32'h0);
        check("arst_stale", 32'(stale), 32'h0);
        check("arst_frameValid", 32'(frameValid), 32'h0);
        check("arst_valueChanged", 32'(valueChanged), 32'h0);
        check("arst_scanError", 32'(scanError), 32'h0);
        blank(0);
        #10 resetN = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) digit(d, frameB[d], 8);
        blank(4);
        check("post_rst_value", value, 32'hEFBEADDE);
        check("post_rst_fv_count", 32'(fvCount), 32'd5);
        check("post_rst_vc_count", 32'(vcCount), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
